// File: rtl/h264dc_hadamard_if.sv
`default_nettype none
// ============================================================================
//  Module      : h264dc_hadamard_if
//  Description : Sample-in / coefficient-out handshake bundle for the DC
//                Hadamard transform.
//  Revision    : 1.0 - initial release
// ============================================================================
interface h264dc_hadamard_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
);
    logic                        mode;
    logic                        enable;
    logic signed [IN_WIDTH-1:0]  xxin;
    logic                        readyi;
    logic                        valid;
    logic signed [OUT_WIDTH-1:0] yyout;
    logic                        yylast;
    logic                        readyo;

    modport master (
        output mode, enable, xxin, readyo,
        input  readyi, valid, yyout, yylast
    );

    modport slave (
        input  mode, enable, xxin, readyo,
        output readyi, valid, yyout, yylast
    );
endinterface
`default_nettype wire

// File: rtl/h264dc_hadamard.sv
`default_nettype none
// ============================================================================
//  Module      : h264dc_hadamard
//  Description : Forward H.264 DC Hadamard, 2x2 chroma or 4x4 luma per block,
//                serial in / serial out with ready/valid on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module h264dc_hadamard #(
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int LUMA_SHIFT   = 1,
    parameter int SUPPORT_LUMA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    h264dc_hadamard_if.slave   bus
);
    localparam int c_W = IN_WIDTH + 4;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   mode_q;
    logic signed [c_W-1:0]  data_q [16];

    logic                   w_mode_in;
    logic                   w_luma;
    logic [3:0]             w_last_idx;
    logic [3:0]             w_idx [4];
    logic signed [c_W-1:0]  w_x [4];
    logic signed [c_W-1:0]  w_t [4];
    logic signed [c_W-1:0]  w_y;
    logic signed [c_W-1:0]  w_shifted;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_mode_in  = (SUPPORT_LUMA != 0) && bus.mode;
    assign w_luma     = (SUPPORT_LUMA != 0) && mode_q;
    assign w_last_idx = w_luma ? 4'd15 : 4'd3;

    // One 4-point butterfly serves both passes: rows while cnt_q < 4, columns after.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_idx[j] = cnt_q[2] ? {j[1:0], cnt_q[1:0]} : {cnt_q[1:0], j[1:0]};
            w_x[j]   = data_q[w_idx[j]];
        end
        w_t[0] = w_x[0] + w_x[1] + w_x[2] + w_x[3];
        w_t[1] = w_x[0] + w_x[1] - w_x[2] - w_x[3];
        w_t[2] = w_x[0] - w_x[1] - w_x[2] + w_x[3];
        w_t[3] = w_x[0] - w_x[1] + w_x[2] - w_x[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus.readyi = 1'b0;
        bus.valid  = 1'b0;
        bus.yylast = 1'b0;
        case (state_q)
            S_LOAD: begin
                bus.readyi = 1'b1;
                if (bus.enable) begin
                    if (cnt_q == w_last_idx) begin
                        state_d = S_CALC;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_CALC: begin
                if (!w_luma || cnt_q == 4'd7) begin
                    state_d = S_DRAIN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                bus.valid  = 1'b1;
                bus.yylast = (cnt_q == w_last_idx);
                if (bus.readyo) begin
                    if (cnt_q == w_last_idx) begin
                        state_d = S_LOAD;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.enable) begin
                        data_q[cnt_q] <= {{4{bus.xxin[IN_WIDTH-1]}}, bus.xxin};
                        if (cnt_q == 4'd0) begin
                            mode_q <= w_mode_in;
                        end
                    end
                end
                S_CALC: begin
                    if (w_luma) begin
                        for (int j = 0; j < 4; j++) begin
                            data_q[w_idx[j]] <= w_t[j];
                        end
                    end else begin
                        // 2x2 raster order y00,y01,y10,y11 maps to butterfly outputs 0,3,1,2.
                        data_q[0] <= w_t[0];
                        data_q[1] <= w_t[3];
                        data_q[2] <= w_t[1];
                        data_q[3] <= w_t[2];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_y       = data_q[cnt_q];
    assign w_shifted = w_luma ? (w_y >>> LUMA_SHIFT) : w_y;

    if (c_W > OUT_WIDTH) begin : g_sat
        logic [c_W-OUT_WIDTH:0] w_top;
        assign w_top = w_shifted[c_W-1:OUT_WIDTH-1];
        assign w_sat = (&w_top || ~|w_top) ? w_shifted[OUT_WIDTH-1:0]
                     : (w_top[c_W-OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUT_WIDTH-1){1'b1}}});
    end else begin : g_ext
        assign w_sat = OUT_WIDTH'(w_shifted);
    end

    assign bus.yyout = bus.valid ? w_sat : '0;
endmodule
`default_nettype wire

// File: tb/tb_h264dc_hadamard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_h264dc_hadamard
//  Description : Directed and randomised bench for h264dc_hadamard against a
//                matrix-product reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_h264dc_hadamard;
    localparam int IW = 16;
    localparam int OW = 16;
    localparam int SH = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    h264dc_hadamard_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    h264dc_hadamard #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .LUMA_SHIFT(SH), .SUPPORT_LUMA(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int xs [16];
    int ys [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int h(input int i, input int j);
        case (i)
            0:       return 1;
            1:       return (j < 2) ? 1 : -1;
            2:       return (j == 0 || j == 3) ? 1 : -1;
            default: return (j == 0 || j == 2) ? 1 : -1;
        endcase
    endfunction

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Y = H*X*H (>>> SH in luma mode), or the 2x2 sum/difference formulas.
    task automatic model(input bit m);
        if (m) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    int s = 0;
                    for (int k = 0; k < 4; k++)
                        for (int l = 0; l < 4; l++)
                            s += h(i, k) * xs[k*4+l] * h(l, j);
                    ys[i*4+j] = sat(s >>> SH);
                end
        end else begin
            ys[0] = sat(xs[0] + xs[1] + xs[2] + xs[3]);
            ys[1] = sat(xs[0] - xs[1] + xs[2] - xs[3]);
            ys[2] = sat(xs[0] + xs[1] - xs[2] - xs[3]);
            ys[3] = sat(xs[0] - xs[1] - xs[2] + xs[3]);
        end
    endtask

    task automatic send(input bit m, input int n, input int stall_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == stall_at) begin
                bus.enable = 1'b0;
                @(negedge clk);
                chk("readyi_stall", 32'(bus.readyi), 32'd1);
            end
            chk($sformatf("readyi_s%0d", i), 32'(bus.readyi), 32'd1);
            bus.enable = 1'b1;
            bus.xxin   = 16'(xs[i]);
            bus.mode   = (i == 0) ? m : 1'($urandom);
        end
        @(negedge clk);
        // Junk with ENABLE high during CALC must be ignored.
        bus.xxin = 16'($urandom);
        chk("readyi_low", 32'(bus.readyi), 32'd0);
    endtask

    task automatic wait_valid(input int c_exp);
        int lat = 0;
        while (bus.valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bus.enable = 1'b0;
        chk("latency", 32'(lat), 32'(c_exp));
    endtask

    task automatic drain(input int n, input int bp, input int abort_after);
        int k = 0;
        int p = 0;
        int cyc = 0;
        bit r;
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        while (k < n && cyc < 200) begin
            if (abort_after >= 0 && k == abort_after) return;
            chk($sformatf("valid[%0d]", k), 32'(bus.valid), 32'd1);
            chk($sformatf("yyout[%0d]", k), 32'(bus.yyout), 32'(ys[k]));
            chk($sformatf("yylast[%0d]", k), 32'(bus.yylast), 32'(k == n - 1));
            case (bp)
                0:       r = 1'b1;
                1:       r = pat[p % 7];
                default: r = 1'($urandom);
            endcase
            bus.readyo = r;
            p++;
            @(posedge clk);
            if (r) k++;
            @(negedge clk);
            cyc++;
        end
        chk("handshakes", 32'(k), 32'(n));
        chk("post_valid", 32'(bus.valid), 32'd0);
        chk("post_readyi", 32'(bus.readyi), 32'd1);
        bus.readyo = 1'b1;
    endtask

    task automatic run(input bit m, input int stall_at, input int bp);
        int n = m ? 16 : 4;
        model(m);
        send(m, n, stall_at);
        wait_valid(m ? 8 : 1);
        drain(n, bp, -1);
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        xs[0] = a; xs[1] = b; xs[2] = c; xs[3] = d;
    endtask

    task automatic fill(input int v0, input int rest);
        xs[0] = v0;
        for (int i = 1; i < 16; i++) xs[i] = rest;
    endtask

    initial begin
        logic signed [15:0] r16;
        bus.mode   = 1'b0;
        bus.enable = 1'b0;
        bus.xxin   = '0;
        bus.readyo = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_readyi", 32'(bus.readyi), 32'd1);
        chk("rst_yyout", 32'(bus.yyout), 32'd0);
        chk("rst_yylast", 32'(bus.yylast), 32'd0);
        rst_n = 1'b1;

        set4(1, 2, 3, 4);          run(1'b0, -1, 0);
        set4(5, 6, 7, 8);          run(1'b0, 2, 0);
        fill(1, 1);                run(1'b1, -1, 0);
        fill(2, 0);                run(1'b1, -1, 0);
        fill(-3, 0);               run(1'b1, -1, 0);
        set4(32767, 32767, 32767, 32767); run(1'b0, -1, 0);
        set4(-7, 300, 12, -1000);  run(1'b0, -1, 1);

        // Abort mid-drain with an asynchronous reset.
        set4(1, 2, 3, 4);
        model(1'b0);
        send(1'b0, 4, -1);
        wait_valid(1);
        drain(4, 0, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.valid), 32'd0);
        chk("arst_readyi", 32'(bus.readyi), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        set4(1, 2, 3, 4);          run(1'b0, -1, 0);

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 16; i++) begin
                r16   = 16'($urandom);
                xs[i] = r16;
            end
            run(1'(b % 2), int'($urandom_range(0, 5)), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/h264dc_hadamard.md
Name: h264dc_hadamard

Overview:
Parametrised successor to the chroma DC transform. Performs the forward H.264 DC Hadamard transform in one of two modes, selected per block:
- 2x2 mode for chroma DC (4 coefficients).
- 4x4 mode for Intra16x16 luma DC (16 coefficients, with a post-shift).

Sits between the core forward transform and the quantiser. Samples enter serially and results leave serially, each side with a ready/valid handshake and downstream backpressure.

Parameters:
IN_WIDTH, 16, signed input sample width
OUT_WIDTH, 16, signed output width; results saturate to this range
LUMA_SHIFT, 1, arithmetic right shift applied to 4x4-mode results (0 disables)
SUPPORT_LUMA, 1, 0 removes 4x4 mode; MODE is then ignored and treated as 0

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
MODE  in  1  0 = 2x2 chroma, 1 = 4x4 luma; sampled with the first sample of a block
ENABLE  in  1  input sample valid
XXIN  in  IN_WIDTH  signed input sample, raster order (row-major)
READYI  out  1  block can accept a sample
VALID  out  1  YYOUT holds a valid coefficient
YYOUT  out  OUT_WIDTH  signed output coefficient, raster order
YYLAST  out  1  high with the final coefficient of a block
READYO  in  1  downstream accepts YYOUT

Behaviour:
- Reset (RESET_N low, asynchronous): state LOAD, sample count 0, VALID=0, YYLAST=0, YYOUT=0, READYI=1. Reset in any state aborts the block; partial data is discarded.
- Block size N: 4 in 2x2 mode, 16 in 4x4 mode.
- A sample is accepted on a rising edge where ENABLE=1 and READYI=1.
- MODE is latched at the acceptance of sample 0. MODE changes mid-block are ignored.
- FSM states: LOAD, CALC, DRAIN.
- LOAD:
  - READYI=1, VALID=0.
  - Each accepted sample is stored at index count; count increments.
  - Acceptance of sample N-1 -> CALC, with READYI=0 from that edge.
  - ENABLE=0 stalls with no state change.
- CALC:
  - 2x2 mode: 1 cycle, computing all 4 results at once.
  - 4x4 mode: 8 cycles. Cycles 0-3 do the row pass, one row per cycle, T = X*H. Cycles 4-7 do the column pass, one column per cycle, Y = H*T.
  - Then -> DRAIN.
  - The first coefficient is therefore visible (VALID=1) C edges after the last-sample edge, with C = 1 (2x2) or 8 (4x4).
- 2x2 math, inputs a=x00, b=x01, c=x10, d=x11:
  - y00 = a+b+c+d
  - y01 = a-b+c-d
  - y10 = a+b-c-d
  - y11 = a-b-c+d
  - No shift.
- 4x4 math:
  - H = [1 1 1 1; 1 1 -1 -1; 1 -1 -1 1; 1 -1 1 -1].
  - Y = (H*X*H) >>> LUMA_SHIFT, arithmetic shift (floor).
- Widths: internal accumulation is IN_WIDTH+4 bits, so no overflow is possible. The final value saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- DRAIN:
  - VALID=1, YYOUT = Y[k] for k = 0..N-1 in raster order.
  - k advances only on edges where READYO=1.
  - While READYO=0, YYOUT, YYLAST and VALID hold stable.
  - YYLAST=1 only while k=N-1.
  - The handshake on k=N-1 -> LOAD: the next cycle has VALID=0, READYI=1 and count=0.
  - No overlap of LOAD with DRAIN. ENABLE during CALC or DRAIN is ignored, since READYI=0.
- Back-to-back blocks carry no state between them.

Test Plan:
- 2x2, MODE=0, XXIN 1,2,3,4 with READYO=1 -> READYI drops after the 4th sample. 1 cycle later YYOUT 10, 0xFFFE, 0xFFFC, 0x0000, with YYLAST on the 4th output. Then READYI=1.
- Second 2x2 block 5,6,7,8, with ENABLE=0 for one cycle between samples 2 and 3 -> stall accepted. Outputs 26, 0xFFFE, 0xFFFC, 0x0000.
- 4x4, MODE=1:
  - all 16 samples =1 -> first VALID 8 cycles after the last sample; YYOUT 8 then fifteen 0.
  - x00=2, others 0 -> sixteen 1s.
  - x00=-3, others 0 -> sixteen 0xFFFE (floor shift).
- Saturation: 2x2, all samples 0x7FFF -> y00=0x7FFF (saturated, true value 131068); y01, y10, y11 = 0.
- Backpressure: 2x2 DRAIN with READYO toggling 1,0,0,1,1,0,1 -> each coefficient is held while READYO=0. Exactly 4 handshakes occur, in order, and YYLAST appears only with the 4th.
- Reset mid-DRAIN: assert RESET_N=0 after 2 outputs -> VALID=0 immediately (asynchronous) and READYI=1. The next 2x2 block 1,2,3,4 yields 10, -2, -4, 0 correctly.
